// File: rtl/booth_mul_if.sv
// Operand/result bundle for booth_mul: start request, operands, busy/done status and product.
// BOOTH_SM_OUT_EN adds the registered sign-magnitude product_sm.
interface booth_mul_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a_comp;
  logic [WIDTH-1:0]     b_comp;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
`ifdef BOOTH_SM_OUT_EN
  logic [2*WIDTH-1:0]   product_sm;

  modport master (
    output start, a_comp, b_comp,
    input  busy, done, product, product_sm
  );

  modport slave (
    input  start, a_comp, b_comp,
    output busy, done, product, product_sm
  );
`else
  modport master (
    output start, a_comp, b_comp,
    input  busy, done, product
  );

  modport slave (
    input  start, a_comp, b_comp,
    output busy, done, product
  );
`endif
endinterface

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, start/busy/done handshake.
// Define BOOTH_SM_OUT_EN to add the registered sign-magnitude output product_sm.
module booth_mul #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  booth_mul_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic [PW-1:0]    prod_new;

`ifdef BOOTH_SM_OUT_EN
  logic [PW-1:0]    sm_q, sm_d;
  logic             sm_sign;
  logic [PW-2:0]    sm_mag;
  logic [PW-1:0]    sm_new;
`endif

  // ACC is one bit wider than M so subtracting M = -2^(WIDTH-1) cannot overflow.
  assign m_ext = {m_q[WIDTH-1], m_q};

  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
  end

  assign acc_sh   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_sh     = {sum[0], q_q[WIDTH-1:1]};
  assign prod_new = {acc_sh[WIDTH-1:0], q_sh};

`ifdef BOOTH_SM_OUT_EN
  // |product| never exceeds 2^(2W-2), so PW-1 magnitude bits always suffice.
  assign sm_sign = prod_new[PW-1];
  assign sm_mag  = sm_sign ? (~prod_new[PW-2:0] + (PW-1)'(1)) : prod_new[PW-2:0];
  assign sm_new  = {sm_sign, sm_mag};
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef BOOTH_SM_OUT_EN
    sm_d    = sm_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.a_comp;
          q_d     = bus.b_comp;
          acc_d   = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          prod_d  = prod_new;
`ifdef BOOTH_SM_OUT_EN
          sm_d    = sm_new;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
`ifdef BOOTH_SM_OUT_EN
      sm_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef BOOTH_SM_OUT_EN
      sm_q    <= sm_d;
`endif
    end
  end

  assign bus.busy    = (state_q == CALC);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;
`ifdef BOOTH_SM_OUT_EN
  assign bus.product_sm = sm_q;
`endif

endmodule

// File: tb/tb_booth_mul.sv
// Scoreboard bench for booth_mul (WIDTH=8): directed corners, ignored start, mid-CALC reset,
// and a long start-held-high run with random operands against a signed a*b reference.
module tb_booth_mul;
  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int N_HELD = 3000;

  typedef struct packed {
    logic [PW-1:0] prod;
    logic [PW-1:0] sm;
  } exp_t;

  logic clk;
  logic rst;
  booth_mul_if #(.WIDTH(W)) bus ();

  booth_mul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_push = 0;
  int n_done = 0;
  int busy_cnt = 0;
  logic [PW-1:0] last_prod = '0;
  exp_t sc_q[$];
  int   acc_q[$];

  logic [15:0] corners [0:7] = '{16'h0305, 16'h8080, 16'h807F, 16'hFFFF,
                                 16'h009C, 16'h7F7F, 16'h7F80, 16'h0180};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain signed multiplication, then sign-magnitude from the integer value.
  function automatic exp_t ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    longint mag;
    logic [63:0] pv;
    logic [63:0] mv;
    p   = longint'($signed(a)) * longint'($signed(b));
    mag = (p < 0) ? -p : p;
    pv  = p;
    mv  = mag;
    e.prod = pv[PW-1:0];
    e.sm   = {(p < 0), mv[PW-2:0]};
    return e;
  endfunction

  // Called at a negedge where the DUT is idle and start is high: the next edge accepts.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    sc_q.push_back(ref_mul(a, b));
    acc_q.push_back(cyc + 1);
    n_push++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (rst) begin
      busy_cnt  = 0;
      last_prod = '0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sc_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sc_q.pop_front();
          t = acc_q.pop_front();
          chk("product", 32'(bus.product), 32'(e.prod));
`ifdef BOOTH_SM_OUT_EN
          chk("product_sm", 32'(bus.product_sm), 32'(e.sm));
`endif
          chk("latency", 32'(cyc - t), 32'(W));
          chk("busy_cycles", 32'(busy_cnt), 32'(W));
          chk("busy_in_done", 32'(bus.busy), 32'd0);
          last_prod = e.prod;
          n_done++;
        end
        busy_cnt = 0;
      end else begin
        chk("product_hold", 32'(bus.product), 32'(last_prod));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) fail_now("issue_timeout");
    bus.a_comp = a;
    bus.b_comp = b;
    bus.start  = 1'b1;
    push(a, b);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a_comp = W'($urandom);
    bus.b_comp = W'($urandom);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sc_q.size() != 0 || bus.busy || bus.done) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) fail_now("drain_timeout");
  endtask

  initial begin
    int n_acc;
    int prev_acc;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.a_comp = '0;
    bus.b_comp = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", 32'(bus.product), 32'd0);
`ifdef BOOTH_SM_OUT_EN
    chk("reset_product_sm", 32'(bus.product_sm), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed corners with single-cycle start pulses.
    issue(8'h03, 8'h05);
    wait_drain();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] c;
      c = corners[i];
      issue(c[15:8], c[7:0]);
      wait_drain();
    end

    // A second start during CALC is ignored; the monitor flags any extra done.
    issue(8'h12, 8'h34);
    repeat (3) @(negedge clk);
    bus.a_comp = 8'h55;
    bus.b_comp = 8'h66;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("ignored_start_done_count", 32'(n_done), 32'(n_push));

    // Asynchronous reset in the middle of CALC aborts without a done pulse.
    issue(8'h40, 8'h33);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    sc_q.delete();
    acc_q.delete();
    n_push--;
    last_prod = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(8'hC3, 8'h5A);
    wait_drain();

    // start held high: back-to-back operations, operands scrambled while not idle.
    n_acc    = 0;
    prev_acc = -1;
    @(negedge clk);
    bus.a_comp = 8'hA5;
    bus.b_comp = 8'h3C;
    bus.start  = 1'b1;
    while (n_acc < N_HELD) begin
      if (!bus.busy && !bus.done) begin
        if (prev_acc >= 0) chk("start_spacing", 32'(cyc + 1 - prev_acc), 32'(W + 2));
        prev_acc = cyc + 1;
        push(bus.a_comp, bus.b_comp);
        n_acc++;
      end else if (n_acc < 8) begin
        logic [15:0] c;
        c = corners[n_acc];
        bus.a_comp = c[15:8];
        bus.b_comp = c[7:0];
      end else begin
        bus.a_comp = W'($urandom);
        bus.b_comp = W'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("total_done_count", 32'(n_done), 32'(n_push));
    chk("scoreboard_empty", 32'(sc_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
